// File: rtl/alu_defs_pkg.sv
// ---------------------------------------------------------------------------
// alu_defs_pkg
//   Shared definitions for the ALU control decoder and the execute stage.
//   - ALU op code localparams (ALU_ADD .. ALU_SLT); codes 1001-1111 are
//     undefined and reported as illegal by the execute stage.
//   - FSM state encoding for alu_seq_exec (IDLE / SHIFT / DONE).
//   - is_shift_op(): true for the op codes that use the iterative shifter.
// ---------------------------------------------------------------------------
package alu_defs_pkg;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_XOR = 4'b0100;
  localparam logic [3:0] ALU_SLL = 4'b0101;
  localparam logic [3:0] ALU_SRL = 4'b0110;
  localparam logic [3:0] ALU_SRA = 4'b0111;
  localparam logic [3:0] ALU_SLT = 4'b1000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  function automatic logic is_shift_op(input logic [3:0] ctrl);
    return (ctrl == ALU_SLL) || (ctrl == ALU_SRL) || (ctrl == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_shift_step.sv
// ---------------------------------------------------------------------------
// alu_shift_step
//   Combinational single-iteration shifter: shifts data by n bits, where n is
//   0..STEP. Only STEP+1 fixed shift amounts exist, so the mux stays small
//   regardless of XLEN.
// Ports
//   data   in   XLEN     value to shift
//   n      in   STEP_W   shift amount for this iteration (0..STEP)
//   left   in   1        1 = shift left, 0 = shift right
//   arith  in   1        right shifts only: 1 = fill with data[XLEN-1]
//   out    out  XLEN     shifted value
// ---------------------------------------------------------------------------
module alu_shift_step #(
  parameter int XLEN   = 32,
  parameter int STEP   = 1,
  parameter int STEP_W = $clog2(STEP + 1)
) (
  input  logic [XLEN-1:0]   data,
  input  logic [STEP_W-1:0] n,
  input  logic              left,
  input  logic              arith,
  output logic [XLEN-1:0]   out
);

  logic [XLEN-1:0] shl_c [0:STEP];
  logic [XLEN-1:0] srl_c [0:STEP];
  logic [XLEN-1:0] sra_c [0:STEP];
  logic [XLEN-1:0] cand  [0:STEP];

  genvar gi;
  generate
    for (gi = 0; gi <= STEP; gi++) begin : g_cand
      assign shl_c[gi] = data << gi;
      assign srl_c[gi] = data >> gi;
      // Kept in its own assignment so the signed operand is not turned
      // unsigned by the surrounding select (which would make >>> logical).
      assign sra_c[gi] = $signed(data) >>> gi;
      assign cand[gi]  = left ? shl_c[gi] : (arith ? sra_c[gi] : srl_c[gi]);
    end
  endgenerate

  always_comb begin
    out = data;
    for (int i = 0; i <= STEP; i++) begin
      if (n == STEP_W'(i)) begin
        out = cand[i];
      end
    end
  end

endmodule

// File: rtl/alu_seq_exec.sv
// ---------------------------------------------------------------------------
// alu_seq_exec
//   Execute stage behind the ALU control decoder. Logic, arithmetic and
//   compare ops finish in one cycle; shifts iterate SHIFT_STEP bits per
//   cycle through alu_shift_step. valid/ready handshake on input and output.
// Ports
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      alu_ctrl/op_a/op_b valid
//   in_ready   out  1      high only in IDLE
//   alu_ctrl   in   4      op code
//   op_a       in   XLEN   operand A
//   op_b       in   XLEN   operand B; shift amount is op_b[SHAMT_W-1:0]
//   out_valid  out  1      result/zero/illegal valid (state DONE)
//   out_ready  in   1      consumer takes the result
//   result     out  XLEN   registered result
//   zero       out  1      result == 0
//   illegal    out  1      alu_ctrl was not a defined code
// ---------------------------------------------------------------------------
module alu_seq_exec
  import alu_defs_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int SHIFT_STEP = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_ctrl,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal
);

  localparam int SHAMT_W = $clog2(XLEN);
  localparam int STEP_W  = $clog2(SHIFT_STEP + 1);

  state_t               state_reg,   state_next;
  logic [XLEN-1:0]      result_reg,  result_next;
  logic                 zero_reg,    zero_next;
  logic                 illegal_reg, illegal_next;
  logic [XLEN-1:0]      work_reg,    work_next;
  logic [SHAMT_W-1:0]   cnt_reg,     cnt_next;
  logic                 left_reg,    left_next;
  logic                 arith_reg,   arith_next;

  logic [SHAMT_W-1:0]   shamt;
  logic [XLEN-1:0]      alu_res;
  logic                 alu_illegal;
  logic [STEP_W-1:0]    step_n;
  logic [XLEN-1:0]      shifted;

  assign shamt     = op_b[SHAMT_W-1:0];
  assign in_ready  = (state_reg == ST_IDLE);
  assign out_valid = (state_reg == ST_DONE);
  assign result    = result_reg;
  assign zero      = zero_reg;
  assign illegal   = illegal_reg;

  // One-cycle datapath. Shift codes only reach this result when shamt is 0,
  // where the answer is simply op_a.
  always_comb begin
    alu_res     = '0;
    alu_illegal = 1'b0;
    case (alu_ctrl)
      ALU_ADD: alu_res = op_a + op_b;
      ALU_SUB: alu_res = op_a - op_b;
      ALU_AND: alu_res = op_a & op_b;
      ALU_OR:  alu_res = op_a | op_b;
      ALU_XOR: alu_res = op_a ^ op_b;
      ALU_SLL, ALU_SRL, ALU_SRA: alu_res = op_a;
      ALU_SLT: alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      default: alu_illegal = 1'b1;
    endcase
  end

  // Final iteration takes only the bits that are left.
  assign step_n = (cnt_reg < SHAMT_W'(SHIFT_STEP)) ? STEP_W'(cnt_reg)
                                                   : STEP_W'(SHIFT_STEP);

  alu_shift_step #(
    .XLEN   (XLEN),
    .STEP   (SHIFT_STEP),
    .STEP_W (STEP_W)
  ) u_shift_step (
    .data  (work_reg),
    .n     (step_n),
    .left  (left_reg),
    .arith (arith_reg),
    .out   (shifted)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      result_reg  <= '0;
      zero_reg    <= 1'b0;
      illegal_reg <= 1'b0;
      work_reg    <= '0;
      cnt_reg     <= '0;
      left_reg    <= 1'b0;
      arith_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      result_reg  <= result_next;
      zero_reg    <= zero_next;
      illegal_reg <= illegal_next;
      work_reg    <= work_next;
      cnt_reg     <= cnt_next;
      left_reg    <= left_next;
      arith_reg   <= arith_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    result_next  = result_reg;
    zero_next    = zero_reg;
    illegal_next = illegal_reg;
    work_next    = work_reg;
    cnt_next     = cnt_reg;
    left_next    = left_reg;
    arith_next   = arith_reg;
    case (state_reg)
      ST_IDLE: begin
        if (in_valid) begin
          if (is_shift_op(alu_ctrl) && (shamt != '0)) begin
            state_next = ST_SHIFT;
            work_next  = op_a;
            cnt_next   = shamt;
            left_next  = (alu_ctrl == ALU_SLL);
            arith_next = (alu_ctrl == ALU_SRA);
          end else begin
            state_next   = ST_DONE;
            result_next  = alu_res;
            zero_next    = (alu_res == '0);
            illegal_next = alu_illegal;
          end
        end
      end
      ST_SHIFT: begin
        work_next = shifted;
        cnt_next  = cnt_reg - SHAMT_W'(step_n);
        if (cnt_next == '0) begin
          state_next   = ST_DONE;
          result_next  = shifted;
          zero_next    = (shifted == '0);
          illegal_next = 1'b0;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_alu_seq_exec.sv
// ---------------------------------------------------------------------------
// tb_alu_seq_exec
//   Directed checks of alu_seq_exec (XLEN=32, SHIFT_STEP=1) with
//   hand-computed expected values; prints one line per transaction.
// ---------------------------------------------------------------------------
module tb_alu_seq_exec;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_ctrl;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        illegal;

  int tests = 0;
  int fails = 0;

  alu_seq_exec #(
    .XLEN       (32),
    .SHIFT_STEP (1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_ctrl  (alu_ctrl),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .illegal   (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one op for exactly one edge; returns #1 after the accept edge.
  task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    chk("in_ready_before_issue", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    alu_ctrl = c;
    op_a     = a;
    op_b     = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic report(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    $display("[TB] op=%b a=%h b=%h -> result=%h zero=%b illegal=%b",
             c, a, b, result, zero, illegal);
  endtask

  // One edge with out_ready high: DONE is consumed, back to IDLE.
  task automatic drain();
    @(posedge clk); #1;
    chk("out_valid_after_drain", {31'd0, out_valid}, 32'd0);
  endtask

  // Bounded wait for out_valid; returns the number of edges it took.
  task automatic wait_valid(input int limit, output int edges);
    edges = 0;
    while (!out_valid && edges < limit) begin
      @(posedge clk); #1;
      edges++;
    end
    if (!out_valid) begin
      chk("wait_valid_timeout", {31'd0, out_valid}, 32'd1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int edges;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    alu_ctrl  = 4'b0000;
    op_a      = '0;
    op_b      = '0;
    out_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_result",    result,              32'd0);
    chk("rst_zero",      {31'd0, zero},       32'd0);
    chk("rst_illegal",   {31'd0, illegal},    32'd0);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready",  {31'd0, in_ready},   32'd1);
    out_ready = 1'b1;

    // ADD with signed overflow wraps, no flags
    issue(4'b0000, 32'h7FFF_FFFF, 32'h0000_0001);
    chk("add_out_valid", {31'd0, out_valid}, 32'd1);
    chk("add_result",    result,              32'h8000_0000);
    chk("add_zero",      {31'd0, zero},       32'd0);
    chk("add_illegal",   {31'd0, illegal},    32'd0);
    report(4'b0000, 32'h7FFF_FFFF, 32'h0000_0001);
    drain();

    // SUB equal -> zero
    issue(4'b0001, 32'd5, 32'd5);
    chk("sub_result", result,        32'd0);
    chk("sub_zero",   {31'd0, zero}, 32'd1);
    report(4'b0001, 32'd5, 32'd5);
    drain();

    // SUB wrap
    issue(4'b0001, 32'd0, 32'd1);
    chk("sub_wrap_result", result, 32'hFFFF_FFFF);
    report(4'b0001, 32'd0, 32'd1);
    drain();

    // SLT signed: -1 < 1
    issue(4'b1000, 32'hFFFF_FFFF, 32'd1);
    chk("slt_neg_result", result, 32'd1);
    report(4'b1000, 32'hFFFF_FFFF, 32'd1);
    drain();

    // SLT signed: 1 < -1 is false
    issue(4'b1000, 32'd1, 32'hFFFF_FFFF);
    chk("slt_pos_result", result,        32'd0);
    chk("slt_pos_zero",   {31'd0, zero}, 32'd1);
    report(4'b1000, 32'd1, 32'hFFFF_FFFF);
    drain();

    // AND / OR
    issue(4'b0010, 32'hFF00_FF00, 32'h0FF0_0FF0);
    chk("and_result", result, 32'h0F00_0F00);
    report(4'b0010, 32'hFF00_FF00, 32'h0FF0_0FF0);
    drain();
    issue(4'b0011, 32'h0000_00F0, 32'h0000_000F);
    chk("or_result", result, 32'h0000_00FF);
    report(4'b0011, 32'h0000_00F0, 32'h0000_000F);
    drain();

    // SRA by 4: four SHIFT edges, in_ready low throughout
    issue(4'b0111, 32'h8000_0000, 32'd4);
    for (int i = 1; i <= 3; i++) begin
      chk("sra_busy_out_valid", {31'd0, out_valid}, 32'd0);
      chk("sra_busy_in_ready",  {31'd0, in_ready},  32'd0);
      @(posedge clk); #1;
    end
    chk("sra_busy_out_valid_e3", {31'd0, out_valid}, 32'd0);
    chk("sra_busy_in_ready_e3",  {31'd0, in_ready},  32'd0);
    @(posedge clk); #1;
    chk("sra_out_valid_e4", {31'd0, out_valid}, 32'd1);
    chk("sra_result",       result,              32'hF800_0000);
    chk("sra_illegal",      {31'd0, illegal},    32'd0);
    report(4'b0111, 32'h8000_0000, 32'd4);
    drain();

    // SLL with shamt bits zero (op_b=0x20): one-cycle path, result = op_a
    issue(4'b0101, 32'h1234_5678, 32'h0000_0020);
    chk("sll0_out_valid", {31'd0, out_valid}, 32'd1);
    chk("sll0_result",    result,              32'h1234_5678);
    report(4'b0101, 32'h1234_5678, 32'h0000_0020);
    drain();

    // Undefined code 1011
    issue(4'b1011, 32'hDEAD_BEEF, 32'h1234_5678);
    chk("ill_out_valid", {31'd0, out_valid}, 32'd1);
    chk("ill_result",    result,              32'd0);
    chk("ill_illegal",   {31'd0, illegal},    32'd1);
    chk("ill_zero",      {31'd0, zero},       32'd1);
    report(4'b1011, 32'hDEAD_BEEF, 32'h1234_5678);
    drain();

    // Back-pressure: XOR result held 3 cycles, pending ADD ignored meanwhile
    out_ready = 1'b0;
    issue(4'b0100, 32'hF0F0_F0F0, 32'h0F0F_0F0F);
    in_valid = 1'b1;
    alu_ctrl = 4'b0000;
    op_a     = 32'd1;
    op_b     = 32'd1;
    for (int i = 0; i < 3; i++) begin
      chk("hold_out_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_result",    result,              32'hFFFF_FFFF);
      chk("hold_in_ready",  {31'd0, in_ready},  32'd0);
      @(posedge clk); #1;
    end
    chk("hold_result_last", result, 32'hFFFF_FFFF);
    report(4'b0100, 32'hF0F0_F0F0, 32'h0F0F_0F0F);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("release_out_valid", {31'd0, out_valid}, 32'd0);
    chk("release_in_ready",  {31'd0, in_ready},  32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("resume_out_valid", {31'd0, out_valid}, 32'd1);
    chk("resume_result",    result,              32'd2);
    report(4'b0000, 32'd1, 32'd1);
    drain();

    // Reset while an SRL by 12 has 10 steps left
    issue(4'b0110, 32'hFFFF_0000, 32'd12);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_in_ready",  {31'd0, in_ready},  32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 14; i++) begin
      @(posedge clk); #1;
      chk("midrst_no_valid", {31'd0, out_valid}, 32'd0);
    end
    $display("[TB] op=0110 a=ffff0000 b=0000000c -> discarded by reset");

    // Same SRL from scratch: 12 edges
    issue(4'b0110, 32'hFFFF_0000, 32'd12);
    wait_valid(40, edges);
    chk("srl_edges",  edges,  32'd12);
    chk("srl_result", result, 32'h000F_FFF0);
    report(4'b0110, 32'hFFFF_0000, 32'd12);
    drain();

    // SLL by XLEN-1: 31 edges
    issue(4'b0101, 32'h0000_0001, 32'd31);
    wait_valid(60, edges);
    chk("sll31_edges",  edges,         32'd31);
    chk("sll31_result", result,        32'h8000_0000);
    chk("sll31_zero",   {31'd0, zero}, 32'd0);
    report(4'b0101, 32'h0000_0001, 32'd31);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
